datamem_responder: RTL and testbench

Data-memory responder on the CPU's MEM-stage load/store request interface. Accepts one 64-bit load or store at a time, completes it after a fixed latency, and returns a single-cycle response. Sits beside `pipeline_CPU`, which is the request initiator and stalls its MEM stage until the response arrives. Byte-addressed, little-endian; supports LDUR/STUR (8 B) and LDURB/STURB (1 B) plus 2 B and 4 B accesses.

---
 rtl/datamem_responder_if.sv | 23 ++
 rtl/datamem_responder.sv | 172 +++++++++++++++++
 tb/tb_datamem_responder.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_responder_if.sv
// Load/store request and response bundle between the CPU MEM stage (master)
// and the data-memory responder (slave).
interface datamem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/datamem_responder.sv
// Byte-addressed little-endian data memory answering one 1/2/4/8-byte access at a time
// after a fixed latency. Define DATAMEM_ALIGN_CHECK_EN to reject misaligned accesses.
module datamem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input logic                clk,
    input logic                reset,
    datamem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic            accept_s;
    logic            access_s;

    logic            wr_r;
    logic [AW-1:0]   ea_r;
    logic [1:0]      size_r;
    logic [63:0]     wdata_r;

    logic            req_ready_r;
    logic            resp_valid_r;
    logic [63:0]     resp_rdata_r;
    logic            resp_err_r;

    logic [7:0]      byte_en_s;
    logic [AW-1:0]   byte_addr_s [8];
    logic [63:0]     load_data_s;
    logic            err_s;
    logic            mem_we_s;

    logic [7:0]      mem_r [DEPTH_BYTES];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; the access fires on the WAIT edge where the counter is exhausted
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        access_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    access_s    = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Byte lanes touched by the access and their wrapped addresses
    always_comb begin
        byte_en_s = 8'h00;
        case (size_r)
            2'd0:    byte_en_s = 8'h01;
            2'd1:    byte_en_s = 8'h03;
            2'd2:    byte_en_s = 8'h0F;
            2'd3:    byte_en_s = 8'hFF;
            default: byte_en_s = 8'h00;
        endcase
        for (int i = 0; i < 8; i++) begin
            byte_addr_s[i] = ea_r + AW'(i);
        end
    end

    // Zero-extended gather of the addressed bytes
    always_comb begin
        load_data_s = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (byte_en_s[i]) begin
                load_data_s[8*i +: 8] = mem_r[byte_addr_s[i]];
            end else begin
                load_data_s[8*i +: 8] = 8'h00;
            end
        end
    end

`ifdef DATAMEM_ALIGN_CHECK_EN
    // Reject accesses whose effective address is not a multiple of the access size
    always_comb begin
        err_s = 1'b0;
        case (size_r)
            2'd0:    err_s = 1'b0;
            2'd1:    err_s = ea_r[0];
            2'd2:    err_s = |ea_r[1:0];
            2'd3:    err_s = |ea_r[2:0];
            default: err_s = 1'b0;
        endcase
    end
`else
    assign err_s = 1'b0;
`endif

    // A reset on the access edge discards the store
    assign mem_we_s = access_s & wr_r & ~err_s & ~reset;

    // Request capture, latency counter and registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r        <= {CW{1'b0}};
            wr_r         <= 1'b0;
            ea_r         <= {AW{1'b0}};
            size_r       <= 2'd0;
            wdata_r      <= 64'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 64'd0;
            resp_err_r   <= 1'b0;
        end else begin
            req_ready_r  <= (state_nxt_s == IDLE);
            resp_valid_r <= access_s;
            if (accept_s) begin
                wr_r    <= bus.req_write;
                ea_r    <= bus.req_addr[AW-1:0];
                size_r  <= bus.req_size;
                wdata_r <= bus.req_wdata;
                cnt_r   <= CW'(LATENCY - 1);
            end else if ((state_r == WAIT) && (cnt_r != {CW{1'b0}})) begin
                cnt_r <= cnt_r - CW'(1'b1);
            end
            if (access_s) begin
                resp_rdata_r <= (wr_r || err_s) ? 64'd0 : load_data_s;
                resp_err_r   <= err_s;
            end
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en_s[i]) begin
                    mem_r[byte_addr_s[i]] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
endmodule

// File: tb/tb_datamem_responder.sv
// Randomized self-checking bench for datamem_responder against a byte-array memory model.
module tb_datamem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    datamem_responder_if bus ();

    datamem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] ref_mem [DEPTH];

    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic int byte_idx(input logic [63:0] addr, input int i);
        return int'((addr + 64'(i)) % 64'(DEPTH));
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [1:0] size);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < nbytes(size); i++) v[8*i +: 8] = ref_mem[byte_idx(addr, i)];
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] d);
        for (int i = 0; i < nbytes(size); i++) ref_mem[byte_idx(addr, i)] = d[8*i +: 8];
    endtask

    function automatic logic exp_err_of(input logic [63:0] addr, input logic [1:0] size);
        logic e;
        e = 1'b0;
`ifdef DATAMEM_ALIGN_CHECK_EN
        e = ((addr % 64'(DEPTH)) % 64'(nbytes(size))) != 64'd0;
`endif
        return e;
    endfunction

    // One transaction: waits for ready, checks response timing, data, error and hold.
    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                          input logic [63:0] wdata, output logic [63:0] rdata, output logic err);
        logic        e_err;
        logic [63:0] e_rdata;
        int          pulses;
        int          pulse_at;
        int          waited;
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_wait: req_ready=%b required 1", bus.req_ready);
        end
        e_err   = exp_err_of(addr, size);
        e_rdata = (wr || e_err) ? 64'd0 : ref_load(addr, size);
        if (wr && !e_err) ref_store(addr, size, wdata);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        pulses   = 0;
        pulse_at = -1;
        rdata    = 64'd0;
        err      = 1'b0;
        for (int j = 0; j <= LAT + 1; j++) begin
            if (j > 0) @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                pulses++;
                pulse_at = j;
                rdata    = bus.resp_rdata;
                err      = bus.resp_err;
            end
        end
        n_cmp++;
        if (pulses != 1 || pulse_at != LAT) begin
            n_bad++;
            $display("FAIL resp_timing: pulses=%0d at=%0d required 1 at %0d", pulses, pulse_at, LAT);
        end
        n_cmp++;
        if (rdata !== e_rdata) begin
            n_bad++;
            $display("FAIL resp_rdata: addr=%h size=%0d got %h required %h", addr, size, rdata, e_rdata);
        end
        n_cmp++;
        if (err !== e_err) begin
            n_bad++;
            $display("FAIL resp_err: addr=%h size=%0d got %b required %b", addr, size, err, e_err);
        end
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.resp_rdata !== e_rdata) begin
            n_bad++;
            $display("FAIL ready_and_hold: ready=%b rdata=%h required 1 and %h", bus.req_ready, bus.resp_rdata, e_rdata);
        end
    endtask

    task automatic test_reset();
        logic [63:0] rd;
        logic        er;
        reset = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 64'h8;
        bus.req_size  = 2'd3;
        bus.req_wdata = 64'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 64'd0 || bus.resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        // Establish known contents so the model matches without relying on power-up values
        for (int a = 0; a < DEPTH; a += 8) begin
            do_req(1'b1, 64'(a), 2'd3, 64'd0, rd, er);
        end
    endtask

    task automatic test_roundtrip();
        logic [63:0] rd;
        logic        er;
        do_req(1'b1, 64'h10, 2'd3, 64'h1122334455667788, rd, er);
        do_req(1'b0, 64'h10, 2'd3, 64'd0, rd, er);
        n_cmp++;
        if (rd !== 64'h1122334455667788) begin
            n_bad++;
            $display("FAIL roundtrip: got %h required 1122334455667788", rd);
        end
    endtask

    task automatic test_byte();
        logic [63:0] rd;
        logic        er;
        do_req(1'b1, 64'h13, 2'd0, 64'hFFFFFFFFFFFFFFAB, rd, er);
        do_req(1'b0, 64'h10, 2'd3, 64'd0, rd, er);
        n_cmp++;
        if (rd !== 64'h11223344AB667788) begin
            n_bad++;
            $display("FAIL byte_merge: got %h required 11223344ab667788", rd);
        end
        do_req(1'b0, 64'h13, 2'd0, 64'd0, rd, er);
        n_cmp++;
        if (rd !== 64'h00000000000000AB) begin
            n_bad++;
            $display("FAIL byte_zext: got %h required 00000000000000ab", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] q_data [$];
        logic        q_err [$];
        logic        rdy;
        logic        wr;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [63:0] wd;
        logic        e_err;
        int          accepted;
        int          pulses;
        accepted = 0;
        pulses   = 0;
        for (int c = 0; c < 36; c++) begin
            if (bus.resp_valid === 1'b1) begin
                pulses++;
                n_cmp++;
                if (q_data.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra_resp: unexpected response at cycle %0d", c);
                end else if (bus.resp_rdata !== q_data[0] || bus.resp_err !== q_err[0]) begin
                    n_bad++;
                    $display("FAIL b2b_resp: got %h/%b required %h/%b", bus.resp_rdata, bus.resp_err, q_data[0], q_err[0]);
                end
                if (q_data.size() != 0) begin
                    void'(q_data.pop_front());
                    void'(q_err.pop_front());
                end
            end
            rdy = bus.req_ready;
            n_cmp++;
            if (c < 32 && rdy !== ((c % 4) == 0)) begin
                n_bad++;
                $display("FAIL b2b_ready: cycle %0d ready=%b required %b", c, rdy, (c % 4) == 0);
            end
            wr   = 1'($urandom_range(0, 1));
            addr = 64'($urandom_range(0, 255));
            size = 2'($urandom_range(0, 3));
            wd   = {$urandom, $urandom};
            bus.req_valid = (c < 32);
            bus.req_write = wr;
            bus.req_addr  = addr;
            bus.req_size  = size;
            bus.req_wdata = wd;
            if (c < 32 && rdy === 1'b1) begin
                accepted++;
                e_err = exp_err_of(addr, size);
                q_data.push_back((wr || e_err) ? 64'd0 : ref_load(addr, size));
                q_err.push_back(e_err);
                if (wr && !e_err) ref_store(addr, size, wd);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        n_cmp++;
        if (pulses != accepted || accepted != 8) begin
            n_bad++;
            $display("FAIL b2b_count: pulses=%0d accepted=%0d required 8 and 8", pulses, accepted);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] rd;
        logic        er;
        logic [63:0] d;
        d = {$urandom, $urandom};
        do_req(1'b1, 64'(DEPTH) + 64'h20, 2'd3, d, rd, er);
        do_req(1'b0, 64'h20, 2'd3, 64'd0, rd, er);
        n_cmp++;
        if (rd !== d) begin
            n_bad++;
            $display("FAIL wrap: got %h required %h", rd, d);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [63:0] rd;
        logic        er;
        int          seen;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 64'h40;
        bus.req_size  = 2'd3;
        bus.req_wdata = 64'hDEAD;
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int j = 0; j < 5; j++) begin
            if (bus.resp_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen != 0 || bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_wait: resp pulses=%0d ready=%b required 0 and 1", seen, bus.req_ready);
        end
        do_req(1'b0, 64'h40, 2'd3, 64'd0, rd, er);
        n_cmp++;
        if (rd !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_discard: got %h required 0", rd);
        end
    endtask

    task automatic test_misalign();
        logic [63:0] rd;
        logic        er;
        logic [63:0] e_rd;
        logic        e_er;
`ifdef DATAMEM_ALIGN_CHECK_EN
        e_rd = 64'd0;
        e_er = 1'b1;
`else
        e_rd = 64'h00000000CAFEBABE;
        e_er = 1'b0;
`endif
        do_req(1'b1, 64'h41, 2'd2, 64'hCAFEBABE, rd, er);
        do_req(1'b0, 64'h41, 2'd2, 64'd0, rd, er);
        n_cmp++;
        if (rd !== e_rd || er !== e_er) begin
            n_bad++;
            $display("FAIL misalign: got %h/%b required %h/%b", rd, er, e_rd, e_er);
        end
        do_req(1'b0, 64'h40, 2'd3, 64'd0, rd, er);
    endtask

    task automatic test_random();
        logic [63:0] rd;
        logic        er;
        logic [63:0] addr;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) addr = {$urandom, $urandom};
            else addr = (64'($urandom_range(0, 7)) * 64'(DEPTH)) + 64'($urandom_range(0, 48)) + 64'(DEPTH - 24);
            do_req(1'($urandom_range(0, 1)), addr, 2'($urandom_range(0, 3)), {$urandom, $urandom}, rd, er);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 64'd0;
        bus.req_size  = 2'd0;
        bus.req_wdata = 64'd0;
        @(negedge clk);
        test_reset();
        test_roundtrip();
        test_byte();
        test_back_to_back();
        test_wrap();
        test_reset_mid_wait();
        test_misalign();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
